sdp_ram_be_pipe: RTL and testbench

Single-clock simple dual-port block RAM with one write port and one read port. Generalises the fixed 1024x16 dual-port RAM: width and depth are parameters, writes use byte enables, read latency is selectable (1 or 2), and read-during-write behaviour is selectable. A read-valid pipeline and a collision flag are added. Sits under packet buffers and line stores as the standard inferred-BRAM primitive.

---
 rtl/sdp_ram_be_pipe.sv | 119 +++++++++++
 tb/tb_sdp_ram_be_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_be_pipe
// Purpose  : simple dual-port RAM with per-lane write enables and a 1- or
//            2-cycle read pipeline that reports same-address collisions.
// Revision : 1.0
// ============================================================================
module sdp_ram_be_pipe #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int BYTE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_collision
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("sdp_ram_be_pipe: DATA_W must be a multiple of BYTE_W");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sdp_ram_be_pipe: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("sdp_ram_be_pipe: RDW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] w_old_word;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_coll;

  // No reset on the array so it maps onto block RAM; rst only gates writes.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign w_old_word = r_mem[rd_addr];
  assign w_coll     = rd_en && wr_en && (rd_addr == wr_addr);

  if (RDW_MODE == 1) begin : g_write_first
    always_comb begin
      w_rd_word = w_old_word;
      if (w_coll) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            w_rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end else begin : g_read_first
    assign w_rd_word = w_old_word;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data      <= '0;
        rd_valid     <= 1'b0;
        rd_collision <= 1'b0;
      end else begin
        rd_valid     <= rd_en;
        rd_collision <= w_coll;
        if (rd_en) begin
          rd_data <= w_rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_valid;
    logic              r_s1_coll;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_data    <= '0;
        r_s1_valid   <= 1'b0;
        r_s1_coll    <= 1'b0;
        rd_data      <= '0;
        rd_valid     <= 1'b0;
        rd_collision <= 1'b0;
      end else begin
        r_s1_valid   <= rd_en;
        r_s1_coll    <= w_coll;
        if (rd_en) begin
          r_s1_data <= w_rd_word;
        end
        rd_valid     <= r_s1_valid;
        rd_collision <= r_s1_coll;
        // Output word only moves on a completing read so it holds otherwise.
        if (r_s1_valid) begin
          rd_data <= r_s1_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_be_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ram_be_pipe
// Purpose  : directed vector table plus reset and random scoreboard sequences.
// Revision : 1.0
// ============================================================================
module tb_sdp_ram_be_pipe;

  localparam int C_LAT = 2;
  localparam int C_RDW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus for the two 16x1024 instances
  logic        t_wr_en = 1'b0, t_rd_en = 1'b0;
  logic [9:0]  t_wr_addr = '0, t_rd_addr = '0;
  logic [1:0]  t_wr_be = '0;
  logic [15:0] t_wr_data = '0;
  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, a_rd_coll, b_rd_valid, b_rd_coll;

  logic        c_wr_en = 1'b0, c_rd_en = 1'b0;
  logic [5:0]  c_wr_addr = '0, c_rd_addr = '0;
  logic [3:0]  c_wr_be = '0;
  logic [31:0] c_wr_data = '0;
  logic [31:0] c_rd_data;
  logic        c_rd_valid, c_rd_coll;

  sdp_ram_be_pipe #(.DATA_W(16), .ADDR_W(10), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_be(t_wr_be),
    .wr_data(t_wr_data), .rd_en(t_rd_en), .rd_addr(t_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_collision(a_rd_coll));

  sdp_ram_be_pipe #(.DATA_W(16), .ADDR_W(10), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_be(t_wr_be),
    .wr_data(t_wr_data), .rd_en(t_rd_en), .rd_addr(t_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_collision(b_rd_coll));

  sdp_ram_be_pipe #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8), .RD_LATENCY(C_LAT), .RDW_MODE(C_RDW)) u_c (
    .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_be(c_wr_be),
    .wr_data(c_wr_data), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_collision(c_rd_coll));

  typedef struct packed {
    logic        we;
    logic [9:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        re;
    logic [9:0]  ra;
    logic        av;
    logic [15:0] ad;
    logic        ac;
    logic        bv;
    logic [15:0] bd;
    logic        bc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a_data"},  32'(a_rd_data),  32'h0);
    chk({tag, " a_valid"}, 32'(a_rd_valid), 32'h0);
    chk({tag, " b_data"},  32'(b_rd_data),  32'h0);
    chk({tag, " b_valid"}, 32'(b_rd_valid), 32'h0);
    chk({tag, " b_coll"},  32'(b_rd_coll),  32'h0);
  endtask

  // a: latency 1, read-first.  b: latency 2, write-first (lags a by one row).
  vec_t vecs [14];

  // random-phase model state
  logic [31:0] mdl [64];
  logic        pv [2];
  logic [31:0] pd [2];
  logic        pc [2];
  logic        cur_v, cur_c, we, re;
  logic [31:0] cur_d, wd, last_d;
  logic [5:0]  wa, ra;
  logic [3:0]  be;

  initial begin
    //                we    wa      be     wd       re    ra       av    ad       ac    bv    bd       bc
    vecs[0]  = '{1'b1, 10'h3FF, 2'b11, 16'hBEEF, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 10'h000, 2'b11, 16'h1234, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b1, 10'h3FF, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b1, 10'h000, 1'b1, 16'h1234, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 10'h005, 2'b11, 16'hAAAA, 1'b0, 10'h000, 1'b0, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0};
    vecs[5]  = '{1'b1, 10'h005, 2'b01, 16'h55CC, 1'b0, 10'h000, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[6]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b1, 10'h005, 1'b1, 16'hAACC, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[7]  = '{1'b1, 10'h005, 2'b00, 16'hFFFF, 1'b1, 10'h005, 1'b1, 16'hAACC, 1'b1, 1'b1, 16'hAACC, 1'b0};
    vecs[8]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b1, 10'h005, 1'b1, 16'hAACC, 1'b0, 1'b1, 16'hAACC, 1'b1};
    vecs[9]  = '{1'b1, 10'h007, 2'b11, 16'h1111, 1'b0, 10'h000, 1'b0, 16'hAACC, 1'b0, 1'b1, 16'hAACC, 1'b0};
    vecs[10] = '{1'b1, 10'h007, 2'b10, 16'h2222, 1'b1, 10'h007, 1'b1, 16'h1111, 1'b1, 1'b0, 16'hAACC, 1'b0};
    vecs[11] = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b1, 10'h007, 1'b1, 16'h2211, 1'b0, 1'b1, 16'h2211, 1'b1};
    vecs[12] = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b0, 10'h000, 1'b0, 16'h2211, 1'b0, 1'b1, 16'h2211, 1'b0};
    vecs[13] = '{1'b0, 10'h000, 2'b00, 16'h0000, 1'b0, 10'h000, 1'b0, 16'h2211, 1'b0, 1'b0, 16'h2211, 1'b0};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset c_data",  c_rd_data,         32'h0);
    chk("reset c_valid", 32'(c_rd_valid),   32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      t_wr_en = vecs[i].we; t_wr_addr = vecs[i].wa; t_wr_be = vecs[i].be; t_wr_data = vecs[i].wd;
      t_rd_en = vecs[i].re; t_rd_addr = vecs[i].ra;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d a_valid", i), 32'(a_rd_valid), 32'(vecs[i].av));
      chk($sformatf("v%0d a_data", i),  32'(a_rd_data),  32'(vecs[i].ad));
      chk($sformatf("v%0d a_coll", i),  32'(a_rd_coll),  32'(vecs[i].ac));
      chk($sformatf("v%0d b_valid", i), 32'(b_rd_valid), 32'(vecs[i].bv));
      chk($sformatf("v%0d b_data", i),  32'(b_rd_data),  32'(vecs[i].bd));
      chk($sformatf("v%0d b_coll", i),  32'(b_rd_coll),  32'(vecs[i].bc));
    end

    // asynchronous reset with a read in flight in b's first stage
    t_rd_en = 1'b1; t_rd_addr = 10'h007;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    @(negedge clk);
    t_wr_en = 1'b1; t_wr_addr = 10'h007; t_wr_be = 2'b11; t_wr_data = 16'h9999;
    t_rd_en = 1'b1; t_rd_addr = 10'h007;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("in rst");
    rst = 1'b0;
    t_wr_en = 1'b0; t_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post rst %0d a_valid", i), 32'(a_rd_valid), 32'h0);
      chk($sformatf("post rst %0d b_valid", i), 32'(b_rd_valid), 32'h0);
    end
    // the write issued during reset must not have landed
    t_rd_en = 1'b1; t_rd_addr = 10'h007;
    @(posedge clk);
    @(negedge clk);
    t_rd_en = 1'b0;
    chk("rst write a_valid", 32'(a_rd_valid), 32'h1);
    chk("rst write a_data",  32'(a_rd_data),  32'h2211);
    @(posedge clk);
    @(negedge clk);
    chk("rst write b_valid", 32'(b_rd_valid), 32'h1);
    chk("rst write b_data",  32'(b_rd_data),  32'h2211);

    // scoreboarded traffic on the 32-bit instance; first 64 cycles fill memory
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0; pc[0] = 1'b0; pc[1] = 1'b0;
    last_d = '0;
    for (int cyc = 0; cyc < 1064; cyc++) begin
      if (cyc < 64) begin
        we = 1'b1; wa = 6'(cyc); be = 4'hF; re = 1'b0; ra = '0;
      end else begin
        we = 1'($urandom_range(0, 1));
        wa = 6'($urandom_range(0, 63));
        be = 4'($urandom_range(0, 15));
        re = 1'($urandom_range(0, 1));
        ra = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) ra = wa;
      end
      wd = $urandom;
      cur_v = re;
      cur_c = re && we && (ra == wa);
      cur_d = mdl[ra];
      for (int l = 0; l < 4; l++) begin
        if (C_RDW == 1 && cur_c && be[l]) cur_d[l*8 +: 8] = wd[l*8 +: 8];
        if (we && be[l]) mdl[wa][l*8 +: 8] = wd[l*8 +: 8];
      end
      c_wr_en = we; c_wr_addr = wa; c_wr_be = be; c_wr_data = wd;
      c_rd_en = re; c_rd_addr = ra;
      @(posedge clk);
      @(negedge clk);
      pv[1] = pv[0]; pd[1] = pd[0]; pc[1] = pc[0];
      pv[0] = cur_v; pd[0] = cur_d; pc[0] = cur_c;
      chk($sformatf("rnd %0d c_valid", cyc), 32'(c_rd_valid), 32'(pv[C_LAT-1]));
      if (pv[C_LAT-1]) begin
        chk($sformatf("rnd %0d c_data", cyc), c_rd_data,       pd[C_LAT-1]);
        chk($sformatf("rnd %0d c_coll", cyc), 32'(c_rd_coll),  32'(pc[C_LAT-1]));
        last_d = pd[C_LAT-1];
      end else begin
        chk($sformatf("rnd %0d c_hold", cyc), c_rd_data,       last_d);
      end
    end
    c_wr_en = 1'b0; c_rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
